// File: rtl/cpu_pkg.sv
// Shared pipeline types for the memory-access stage: Execute/Writeback payloads,
// control bits, MA state encoding and the default data-memory timeout.
package cpu_pkg;

   localparam int DMEM_TIMEOUT_DEF = 16;

   typedef struct packed {
      logic isLd;
      logic isSt;
      logic isCall;
      logic isWb;
   } ctrl_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      ctrl_t       ctrl;
      logic [31:0] alu_result;
      logic [31:0] op2;
   } Ex_Ma_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      ctrl_t       ctrl;
      logic [31:0] alu_result;
      logic [31:0] Ld_load;
   } Ma_Wb_t;

   // Portion of an instruction that must survive an outstanding memory access
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      ctrl_t       ctrl;
      logic [31:0] alu_result;
   } ma_hold_t;

   typedef enum logic [0:0] {
      MA_IDLE   = 1'b0,
      MA_ACCESS = 1'b1
   } ma_state_e;

   localparam Ma_Wb_t   MA_WB_ZERO   = {$bits(Ma_Wb_t){1'b0}};
   localparam ma_hold_t MA_HOLD_ZERO = {$bits(ma_hold_t){1'b0}};

   function automatic logic is_mem(input ctrl_t c);
      return c.isLd | c.isSt;
   endfunction

   function automatic ma_hold_t to_hold(input Ex_Ma_t ex);
      ma_hold_t h;
      h.pc         = ex.pc;
      h.instr      = ex.instr;
      h.ctrl       = ex.ctrl;
      h.alu_result = ex.alu_result;
      return h;
   endfunction

   // keep_wb=0 retires the instruction without a register-file write
   function automatic Ma_Wb_t retire_rec(input ma_hold_t h, input logic keep_wb,
                                         input logic [31:0] load);
      Ma_Wb_t r;
      r.pc          = h.pc;
      r.instr       = h.instr;
      r.ctrl        = h.ctrl;
      r.ctrl.isWb   = h.ctrl.isWb & keep_wb;
      r.alu_result  = h.alu_result;
      r.Ld_load     = load;
      return r;
   endfunction

endpackage

// File: rtl/ma_dmem_ctrl.sv
// Data-memory access controller: IDLE/ACCESS FSM, wait-state timeout counter and
// registered dmem_req/we/addr/wdata drive.
module ma_dmem_ctrl
   import cpu_pkg::*;
#(
   parameter int DMEM_TIMEOUT = DMEM_TIMEOUT_DEF,
   parameter int AW           = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          issue,
   input  logic          issue_we,
   input  logic [AW-1:0] issue_addr,
   input  logic [31:0]   issue_wdata,
   input  logic          dmem_ack,
   output ma_state_e     state,
   output logic          acked,
   output logic          timed_out,
   output logic          dmem_req,
   output logic          dmem_we,
   output logic [AW-1:0] dmem_addr,
   output logic [31:0]   dmem_wdata
);

   localparam int            CW       = (DMEM_TIMEOUT > 2) ? $clog2(DMEM_TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DMEM_TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACCESS = 1'b1;

   logic [0:0]    fsm;
   logic [CW-1:0] cnt;
   logic          in_access;

   assign in_access = (fsm == ST_ACCESS);
   assign state     = in_access ? MA_ACCESS : MA_IDLE;
   // An ack on the final counted cycle still completes the access normally
   assign acked     = in_access & dmem_ack;
   assign timed_out = in_access & ~dmem_ack & (cnt == CNT_LAST);

   // FSM, wait counter and request strobe
   always_ff @(posedge clk) begin
      if (!rst) begin
         fsm      <= ST_IDLE;
         cnt      <= CNT_ZERO;
         dmem_req <= 1'b0;
      end else begin
         case (fsm)
            ST_IDLE: begin
               if (issue) begin
                  fsm      <= ST_ACCESS;
                  cnt      <= CNT_ZERO;
                  dmem_req <= 1'b1;
               end else begin
                  fsm      <= ST_IDLE;
                  cnt      <= CNT_ZERO;
                  dmem_req <= 1'b0;
               end
            end
            ST_ACCESS: begin
               if (acked || timed_out) begin
                  fsm      <= ST_IDLE;
                  cnt      <= CNT_ZERO;
                  dmem_req <= 1'b0;
               end else begin
                  fsm      <= ST_ACCESS;
                  cnt      <= cnt + CNT_ONE;
                  dmem_req <= 1'b1;
               end
            end
            default: begin
               fsm      <= ST_IDLE;
               cnt      <= CNT_ZERO;
               dmem_req <= 1'b0;
            end
         endcase
      end
   end

   // Request qualifiers latch on issue and stay stable for the whole access
   always_ff @(posedge clk) begin
      if (!rst) begin
         dmem_we    <= 1'b0;
         dmem_addr  <= {AW{1'b0}};
         dmem_wdata <= 32'h0000_0000;
      end else if (issue && !in_access) begin
         dmem_we    <= issue_we;
         dmem_addr  <= issue_addr;
         dmem_wdata <= issue_wdata;
      end else begin
         dmem_we    <= dmem_we;
         dmem_addr  <= dmem_addr;
         dmem_wdata <= dmem_wdata;
      end
   end

endmodule

// File: rtl/ma_stage.sv
// Memory-access pipeline stage: retires non-memory instructions in one cycle and
// stalls on loads/stores until dmem ack or timeout. Optional macro MA_ALIGN_CHK_EN.
module ma_stage
   import cpu_pkg::*;
#(
   parameter int DMEM_TIMEOUT = DMEM_TIMEOUT_DEF,
   parameter int AW           = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  Ex_Ma_t        Ex_Ma_q,
   input  logic          Ex_Ma_vld,
   output logic          ma_stall,
   output logic          dmem_req,
   output logic          dmem_we,
   output logic [AW-1:0] dmem_addr,
   output logic [31:0]   dmem_wdata,
   input  logic [31:0]   dmem_rdata,
   input  logic          dmem_ack,
   output Ma_Wb_t        Ma_Wb_q,
   output logic          Ma_Wb_vld,
   output logic          ma_err
);

   ma_state_e state;
   ma_hold_t  hold;
   logic      accept;
   logic      mem_op;
   logic      misalign;
   logic      issue;
   logic      align_fault;
   logic      acked;
   logic      timed_out;

`ifdef MA_ALIGN_CHK_EN
   assign misalign = (Ex_Ma_q.alu_result[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   assign ma_stall    = (state == MA_ACCESS);
   assign accept      = ~ma_stall & start & Ex_Ma_vld;
   assign mem_op      = accept & is_mem(Ex_Ma_q.ctrl);
   assign issue       = mem_op & ~misalign;
   assign align_fault = mem_op & misalign;

   ma_dmem_ctrl #(
      .DMEM_TIMEOUT (DMEM_TIMEOUT),
      .AW           (AW)
   ) u_dmem_ctrl (
      .clk         (clk),
      .rst         (rst),
      .issue       (issue),
      .issue_we    (Ex_Ma_q.ctrl.isSt),
      .issue_addr  (Ex_Ma_q.alu_result[AW-1:0]),
      .issue_wdata (Ex_Ma_q.op2),
      .dmem_ack    (dmem_ack),
      .state       (state),
      .acked       (acked),
      .timed_out   (timed_out),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .dmem_addr   (dmem_addr),
      .dmem_wdata  (dmem_wdata)
   );

   // Hold register keeps the memory instruction while the access is outstanding
   always_ff @(posedge clk) begin
      if (!rst) begin
         hold <= MA_HOLD_ZERO;
      end else if (issue) begin
         hold <= to_hold(Ex_Ma_q);
      end else begin
         hold <= hold;
      end
   end

   // Writeback output register; Ma_Wb_q holds between retirements
   always_ff @(posedge clk) begin
      if (!rst) begin
         Ma_Wb_q   <= MA_WB_ZERO;
         Ma_Wb_vld <= 1'b0;
      end else if (acked) begin
         Ma_Wb_q   <= retire_rec(hold, 1'b1, hold.ctrl.isLd ? dmem_rdata : 32'h0000_0000);
         Ma_Wb_vld <= 1'b1;
      end else if (timed_out) begin
         Ma_Wb_q   <= retire_rec(hold, 1'b0, 32'h0000_0000);
         Ma_Wb_vld <= 1'b1;
      end else if (accept && !issue) begin
         Ma_Wb_q   <= retire_rec(to_hold(Ex_Ma_q), ~align_fault, 32'h0000_0000);
         Ma_Wb_vld <= 1'b1;
      end else begin
         Ma_Wb_q   <= Ma_Wb_q;
         Ma_Wb_vld <= 1'b0;
      end
   end

   // Sticky error: timed-out access or rejected misaligned access
   always_ff @(posedge clk) begin
      if (!rst) begin
         ma_err <= 1'b0;
      end else if (timed_out || align_fault) begin
         ma_err <= 1'b1;
      end else begin
         ma_err <= ma_err;
      end
   end

endmodule

// File: tb/tb_ma_stage.sv
// Bench for ma_stage: directed vector table, hand-written reset/idle sequences and
// random transactions checked against a transaction-level reference model.
module tb_ma_stage;
   import cpu_pkg::*;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   Ex_Ma_t      Ex_Ma_q;
   logic        Ex_Ma_vld;
   logic        ma_stall;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;
   Ma_Wb_t      Ma_Wb_q;
   logic        Ma_Wb_vld;
   logic        ma_err;

   always #5 clk = ~clk;

   ma_stage #(.DMEM_TIMEOUT(TO), .AW(32)) dut (
      .clk(clk), .rst(rst), .start(start), .Ex_Ma_q(Ex_Ma_q), .Ex_Ma_vld(Ex_Ma_vld),
      .ma_stall(ma_stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .Ma_Wb_q(Ma_Wb_q), .Ma_Wb_vld(Ma_Wb_vld), .ma_err(ma_err)
   );

   int     total = 0;
   int     bad = 0;
   Ma_Wb_t last_wb;
   logic   err_exp;

   typedef struct {
      Ex_Ma_t      ex;
      int          w;
      logic [31:0] rd;
      logic        exp_wb;
      logic [31:0] exp_ld;
   } vec_t;
   vec_t vecs[6];

   task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic Ex_Ma_t mk(input logic [31:0] pc, input logic [31:0] ins, input logic ld,
                                 input logic st, input logic call, input logic wb,
                                 input logic [31:0] alu, input logic [31:0] op2);
      Ex_Ma_t e;
      e.pc = pc; e.instr = ins;
      e.ctrl.isLd = ld; e.ctrl.isSt = st; e.ctrl.isCall = call; e.ctrl.isWb = wb;
      e.alu_result = alu; e.op2 = op2;
      return e;
   endfunction

   function automatic bit misaligned(input Ex_Ma_t ex);
`ifdef MA_ALIGN_CHK_EN
      return (ex.ctrl.isLd || ex.ctrl.isSt) && (ex.alu_result % 4 != 0);
`else
      return (ex.pc != ex.pc);
`endif
   endfunction

   // Reference: what Writeback must see for an instruction whose ack arrives after w waits
   function automatic Ma_Wb_t model(input Ex_Ma_t ex, input int w, input logic [31:0] rd);
      Ma_Wb_t r;
      r.pc = ex.pc; r.instr = ex.instr; r.ctrl = ex.ctrl;
      r.alu_result = ex.alu_result; r.Ld_load = 32'h0;
      if (ex.ctrl.isLd || ex.ctrl.isSt) begin
         if (misaligned(ex) || w >= TO) r.ctrl.isWb = 1'b0;
         else if (ex.ctrl.isLd) r.Ld_load = rd;
      end
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_txn(input Ex_Ma_t ex, input int w, input logic [31:0] rd, input Ma_Wb_t exp);
      bit is_m;
      bit done;
      is_m = (ex.ctrl.isLd || ex.ctrl.isSt) && !misaligned(ex);
      Ex_Ma_q = ex; Ex_Ma_vld = 1'b1; start = 1'b1; dmem_ack = 1'b0;
      step();
      if (!is_m) begin
         if (ex.ctrl.isLd || ex.ctrl.isSt) err_exp = 1'b1;
         chk("nm_vld", Ma_Wb_vld, 1'b1);
         chk("nm_q", Ma_Wb_q, exp);
         chk("nm_req", dmem_req, 1'b0);
         chk("nm_stall", ma_stall, 1'b0);
         chk("nm_err", ma_err, err_exp);
         last_wb = exp;
         return;
      end
      chk("acc_req", dmem_req, 1'b1);
      chk("acc_we", dmem_we, ex.ctrl.isSt);
      chk("acc_addr", dmem_addr, ex.alu_result);
      chk("acc_wdata", dmem_wdata, ex.op2);
      chk("acc_stall", ma_stall, 1'b1);
      chk("acc_vld0", Ma_Wb_vld, 1'b0);
      chk("acc_hold", Ma_Wb_q, last_wb);
      // upstream already shows the next instruction; it must be ignored while stalled
      Ex_Ma_q = mk($urandom, $urandom, 1'b0, 1'b0, 1'b0, 1'b1, $urandom, $urandom);
      done = 1'b0;
      for (int k = 0; k < TO && !done; k++) begin
         start = 1'($urandom_range(0, 1));
         dmem_ack = (k == w);
         dmem_rdata = (k == w) ? rd : $urandom;
         step();
         dmem_ack = 1'b0;
         if (k == w || k == TO - 1) begin
            if (k != w) err_exp = 1'b1;
            chk("ret_vld", Ma_Wb_vld, 1'b1);
            chk("ret_q", Ma_Wb_q, exp);
            chk("ret_req", dmem_req, 1'b0);
            chk("ret_stall", ma_stall, 1'b0);
            chk("ret_err", ma_err, err_exp);
            last_wb = exp;
            done = 1'b1;
         end else begin
            chk("wait_vld", Ma_Wb_vld, 1'b0);
            chk("wait_stall", ma_stall, 1'b1);
            chk("wait_req", dmem_req, 1'b1);
         end
      end
      Ex_Ma_vld = 1'b0;
   endtask

   task automatic set_vec(input int i, input Ex_Ma_t ex, input int w, input logic [31:0] rd,
                          input logic wb, input logic [31:0] ld);
      vecs[i].ex = ex; vecs[i].w = w; vecs[i].rd = rd;
      vecs[i].exp_wb = wb; vecs[i].exp_ld = ld;
   endtask

   initial begin
      Ma_Wb_t exp;
      Ex_Ma_t ex;
      int     w;
      logic [31:0] rd;

      rst = 1'b0; start = 1'b0; Ex_Ma_vld = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
      Ex_Ma_q = mk(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step(); step();
      chk("rst_vld", Ma_Wb_vld, 1'b0);
      chk("rst_q", Ma_Wb_q, MA_WB_ZERO);
      chk("rst_req", dmem_req, 1'b0);
      chk("rst_we", dmem_we, 1'b0);
      chk("rst_addr", dmem_addr, 32'h0);
      chk("rst_wdata", dmem_wdata, 32'h0);
      chk("rst_err", ma_err, 1'b0);
      chk("rst_stall", ma_stall, 1'b0);
      rst = 1'b1;
      last_wb = MA_WB_ZERO;
      err_exp = 1'b0;

      set_vec(0, mk(32'h100, 32'h0000_0033, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 32'h5), 0, 32'h0, 1'b1, 32'h0);
      set_vec(1, mk(32'h104, 32'h0000_0003, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h0), 3, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D);
      set_vec(2, mk(32'h108, 32'h0000_0023, 1'b0, 1'b1, 1'b0, 1'b0, 32'h80, 32'h1234), 0, 32'hDEAD_BEEF, 1'b0, 32'h0);
      set_vec(3, mk(32'h10C, 32'h0000_006F, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 32'h7), 0, 32'h0, 1'b1, 32'h0);
      set_vec(4, mk(32'h110, 32'h0000_0003, 1'b1, 1'b0, 1'b0, 1'b1, 32'h48, 32'h0), 15, 32'h0000_0001, 1'b1, 32'h0000_0001);
      set_vec(5, mk(32'h114, 32'h0000_0003, 1'b1, 1'b0, 1'b0, 1'b1, 32'h44, 32'h0), 16, 32'h0, 1'b0, 32'h0);

      for (int i = 0; i < 6; i++) begin
         exp = model(vecs[i].ex, 0, 32'h0);
         exp.ctrl.isWb = vecs[i].exp_wb;
         exp.Ld_load = vecs[i].exp_ld;
         run_txn(vecs[i].ex, vecs[i].w, vecs[i].rd, exp);
      end

      // late ack after the timeout must not produce a retirement
      dmem_ack = 1'b1; dmem_rdata = 32'h5555_AAAA;
      step();
      dmem_ack = 1'b0;
      chk("late_vld", Ma_Wb_vld, 1'b0);
      chk("late_req", dmem_req, 1'b0);
      chk("late_q", Ma_Wb_q, last_wb);
      chk("late_err", ma_err, 1'b1);

      // start low: valid instruction is not accepted and outputs hold
      Ex_Ma_q = mk(32'h200, 32'h33, 1'b0, 1'b0, 1'b0, 1'b1, 32'h99, 32'h0);
      Ex_Ma_vld = 1'b1; start = 1'b0;
      step();
      chk("nostart_vld", Ma_Wb_vld, 1'b0);
      chk("nostart_q", Ma_Wb_q, last_wb);
      Ex_Ma_vld = 1'b0;

      // reset during the second ACCESS cycle, then a stray ack
      Ex_Ma_q = mk(32'h300, 32'h3, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h0);
      Ex_Ma_vld = 1'b1; start = 1'b1;
      step();
      Ex_Ma_vld = 1'b0;
      chk("r5_req", dmem_req, 1'b1);
      step();
      rst = 1'b0;
      step();
      rst = 1'b1;
      chk("r5_req0", dmem_req, 1'b0);
      chk("r5_stall", ma_stall, 1'b0);
      chk("r5_err", ma_err, 1'b0);
      chk("r5_q", Ma_Wb_q, MA_WB_ZERO);
      dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
      step();
      dmem_ack = 1'b0;
      chk("r5_vld", Ma_Wb_vld, 1'b0);
      chk("r5_req1", dmem_req, 1'b0);
      chk("r5_q1", Ma_Wb_q, MA_WB_ZERO);
      last_wb = MA_WB_ZERO;
      err_exp = 1'b0;

`ifdef MA_ALIGN_CHK_EN
      ex = mk(32'h400, 32'h3, 1'b1, 1'b0, 1'b0, 1'b1, 32'h41, 32'h0);
      exp = model(ex, 0, 32'h0);
      exp.ctrl.isWb = 1'b0;
      run_txn(ex, 0, 32'h0, exp);
      chk("align_err", ma_err, 1'b1);
`endif

      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 3))
            0: ex = mk($urandom, $urandom, 1'b0, 1'b0, 1'b0, 1'b1, $urandom, $urandom);
            1: ex = mk($urandom, $urandom, 1'b1, 1'b0, 1'b0, 1'b1, $urandom, $urandom);
            2: ex = mk($urandom, $urandom, 1'b0, 1'b1, 1'b0, 1'b0, $urandom, $urandom);
            default: ex = mk($urandom, $urandom, 1'b0, 1'b0, 1'b1, 1'b1, $urandom, $urandom);
         endcase
         w = ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(0, 4));
         rd = $urandom;
         run_txn(ex, w, rd, model(ex, w, rd));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
